clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 27, counter/divisor width (covers 100 MHz -> 1 Hz).
REQ-003 SHALL have parameter DEF_HALF, default 50_000_000, half-period loaded into every channel at reset.
REQ-004 SHALL have port master_clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ch_en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port div_wr  input  1  single-cycle divisor write strobe.
REQ-008 SHALL have port div_sel  input  max(1,$clog2(NUM_CH))  channel index for the write.
REQ-009 SHALL have port div_val  input  CNT_W  new half-period in master_clk cycles.
REQ-010 SHALL have port div_ack  output  NUM_CH  one-cycle pulse when the written divisor takes effect.
REQ-011 SHALL have port clk_out  output  NUM_CH  50%-duty divided clock per channel.
REQ-012 SHALL have port tick  output  NUM_CH  one-cycle enable pulse per clk_out rising edge.

Function
REQ-013 Each channel SHALL hold registers cnt, half, pend_val and pend flag; effective half h = max(half,1).
REQ-014 Running channel SHALL increment cnt each cycle; at cnt == h-1, cnt <= 0 and clk_out toggles (period 2h cycles).
REQ-015 tick SHALL be high for exactly the cycle in which registered clk_out transitions 0->1, aligned with it.
REQ-016 div_wr with div_sel < NUM_CH SHALL set pend_val <= div_val, pend <= 1; a write while pend is set SHALL overwrite it (last wins, one ack).
REQ-017 div_wr with div_sel >= NUM_CH SHALL be ignored with no ack.
REQ-018 Running channel SHALL apply pend only at the wrap where clk_out goes 1->0 (full-period boundary): half <= pend_val, pend <= 0, div_ack pulses that cycle.
REQ-019 A write landing on the apply cycle of the same channel SHALL apply the old pending value and leave the new value pending.
REQ-020 Disabled channel (ch_en=0): cnt held 0, clk_out 0, tick 0; pending value applied the next cycle with div_ack.
REQ-021 Re-enable SHALL restart from cnt=0, clk_out=0; first tick after h cycles.
REQ-022 Deassertion of ch_en mid-period SHALL force clk_out low next cycle with no tick.
REQ-023 Channels SHALL be fully independent; no cross-channel phase relation is guaranteed except after common reset/enable.

Reset
REQ-024 rst_n low SHALL asynchronously set cnt=0, half=DEF_HALF, pend=0, clk_out=0, tick=0, div_ack=0 on all channels.
REQ-025 Reset deassertion mid-operation SHALL discard pending writes; the first tick occurs DEF_HALF cycles after the first enabled cycle.

Configuration
REQ-026 Macro CLK_DIV_BANK_PAUSE_EN defined: SHALL add input port pause (1 bit); while high, all cnt and clk_out hold, tick and div_ack are 0, writes are captured but not applied.
REQ-027 Macro CLK_DIV_BANK_PAUSE_EN undefined: SHALL have no pause port; behaviour identical to pause tied 0.

Structure
REQ-028 Package clk_div_pkg SHALL hold CNT_W default, DEF_HALF default and named constants for the game rates (one-Hz, display, fall, pixel half-periods at 100 MHz).
REQ-029 Per-channel logic SHALL be sub-module clk_div_ch, instantiated NUM_CH times via generate.

Verification
REQ-030 Reset with DEF_HALF=3, ch_en=4'b0001 -> clk_out[0] period 6 cycles, tick every 6th cycle, other channels stay 0.
REQ-031 Ch0 running h=3, write div_val=5 mid-high phase -> no change until next 1->0 wrap; div_ack[0] there; subsequent period 10.
REQ-032 Two writes (7 then 2) before boundary -> single div_ack, period becomes 4.
REQ-033 div_val=0 and div_val=1 -> both give period 2, tick every 2nd cycle; div_sel=5 with NUM_CH=4 -> no ack, no change.
REQ-034 Drop ch_en while clk_out high, write 4, re-enable -> clk_out low immediately, ack next cycle, first tick 4 cycles after re-enable.
REQ-035 With CLK_DIV_BANK_PAUSE_EN: pause 10 cycles mid-period -> outputs frozen, no ticks; resume continues from held cnt; async rst_n pulse mid-pause -> all outputs 0 at once.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Purpose  : Shared defaults, game-rate half-periods (100 MHz master clock)
//             and a select-width helper for the clock divider bank.
//  Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

    // Counter width that covers a 100 MHz -> 1 Hz half-period.
    localparam int CNT_W_DEF    = 27;
    // Half-period loaded into every channel at reset (1 Hz at 100 MHz).
    localparam int DEF_HALF_DEF = 50_000_000;

    // Half-periods, in 100 MHz master cycles, for the game's rates.
    localparam int ONE_HZ_HALF  = 50_000_000;  // 1 Hz seconds tick
    localparam int DISPLAY_HALF = 50_000;      // 1 kHz display multiplex
    localparam int FALL_HALF    = 25_000_000;  // 2 Hz piece fall
    localparam int PIXEL_HALF   = 2;           // 25 MHz pixel clock

    // Channel-select width; never zero so a single-channel bank still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ch
//  Purpose  : One 50%-duty divider channel with a pending-divisor register
//             that is applied only at a full-period boundary (or at once
//             while the channel is disabled).
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             pause_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] val_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             ack_o
);

    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;

    logic [CNT_W-1:0] w_h;
    logic             w_apply;

    // A zero divisor behaves as one so the channel always toggles.
    assign w_h = (half_q == '0) ? c_one : half_q;

    // Next-state: count/toggle, boundary apply of the pending divisor, capture of writes.
    always_comb begin
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        w_apply    = 1'b0;

        if (!pause_i) begin
            if (!en_i) begin
                cnt_d   = '0;
                clk_d   = 1'b0;
                w_apply = pend_q;
            end else if (cnt_q == w_h - c_one) begin
                cnt_d   = '0;
                clk_d   = ~clk_q;
                tick_d  = ~clk_q;
                // Only the falling wrap closes a full period.
                w_apply = clk_q & pend_q;
            end else begin
                cnt_d = cnt_q + c_one;
            end
        end

        if (w_apply) begin
            half_d = pend_val_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // A write on the apply cycle lands after the old value was consumed,
        // so it stays pending for the next boundary.
        if (wr_i) begin
            pend_val_d = val_i;
            pend_d     = 1'b1;
        end
    end

    // Channel state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            half_q     <= c_def_half;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign ack_o  = ack_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_bank
//  Purpose  : Bank of NUM_CH independent 50%-duty clock dividers sharing one
//             divisor write port; each channel also emits a one-cycle tick
//             on its rising output edge.
//  Options  : CLK_DIV_BANK_PAUSE_EN - adds a global 'pause' input that
//             freezes every channel (writes are still captured).
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic                         master_clk,
    input  logic                         rst_n,
`ifdef CLK_DIV_BANK_PAUSE_EN
    input  logic                         pause,
`endif
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         div_wr,
    input  logic [sel_width(NUM_CH)-1:0] div_sel,
    input  logic [CNT_W-1:0]             div_val,
    output logic [NUM_CH-1:0]            div_ack,
    output logic [NUM_CH-1:0]            clk_out,
    output logic [NUM_CH-1:0]            tick
);

    localparam int SEL_W = sel_width(NUM_CH);

    logic w_pause;

`ifdef CLK_DIV_BANK_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Out-of-range selects match no channel and are therefore dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic w_wr;

        assign w_wr = div_wr && (div_sel == SEL_W'(gi));

        clk_div_ch #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk_i   (master_clk),
            .rst_ni  (rst_n),
            .en_i    (ch_en[gi]),
            .pause_i (w_pause),
            .wr_i    (w_wr),
            .val_i   (div_val),
            .clk_o   (clk_out[gi]),
            .tick_o  (tick[gi]),
            .ack_o   (div_ack[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_bank
//  Purpose  : Self-checking bench for clk_div_bank. Five channels are used so
//             that div_sel=5 is a representable out-of-range index.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int SW  = sel_width(NCH);

    logic           master_clk = 1'b0;
    logic           rst_n      = 1'b0;
    logic           div_wr     = 1'b0;
    logic [NCH-1:0] ch_en      = '0;
    logic [SW-1:0]  div_sel    = '0;
    logic [CW-1:0]  div_val    = '0;
    logic [NCH-1:0] div_ack;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
`ifdef CLK_DIV_BANK_PAUSE_EN
    logic           pause      = 1'b0;
`endif

    clk_div_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DEF_HALF (3)
    ) dut (
        .master_clk (master_clk),
        .rst_n      (rst_n),
`ifdef CLK_DIV_BANK_PAUSE_EN
        .pause      (pause),
`endif
        .ch_en      (ch_en),
        .div_wr     (div_wr),
        .div_sel    (div_sel),
        .div_val    (div_val),
        .div_ack    (div_ack),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    always #5 master_clk = ~master_clk;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    bit mon    = 1'b0;
    int exp_tick_q[$];
    int exp_ack_q[$];

    typedef struct {
        int val;
        int period;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit later. Scoreboard for ch0.
    task automatic step();
        @(posedge master_clk);
        #1;
        cyc++;
        if (mon) begin
            if (exp_tick_q.size() > 0 && exp_tick_q[0] == cyc) begin
                check("sb_tick", int'(tick[0]), 1);
                exp_tick_q.delete(0);
            end else if (tick[0]) begin
                check("sb_tick_unexpected", 1, 0);
            end
            if (exp_ack_q.size() > 0 && exp_ack_q[0] == cyc) begin
                check("sb_ack", int'(div_ack[0]), 1);
                exp_ack_q.delete(0);
            end else if (div_ack[0]) begin
                check("sb_ack_unexpected", 1, 0);
            end
        end
    endtask

    task automatic mon_done();
        mon = 1'b0;
        check("sb_tick_left", exp_tick_q.size(), 0);
        check("sb_ack_left", exp_ack_q.size(), 0);
        exp_tick_q.delete();
        exp_ack_q.delete();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic write(input int sel, input int val);
        div_wr  = 1'b1;
        div_sel = SW'(sel);
        div_val = CW'(val);
        step();
        div_wr  = 1'b0;
    endtask

    task automatic wait_tick(input int ch, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 64 && at < 0) begin
            step();
            n++;
            if (tick[ch]) at = cyc;
        end
        if (at < 0) check("wait_tick_timeout", 0, 1);
    endtask

    task automatic wait_ack(input int ch, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 64 && at < 0) begin
            step();
            n++;
            if (div_ack[ch]) at = cyc;
        end
        if (at < 0) check("wait_ack_timeout", 0, 1);
    endtask

    task automatic sync_tick(input int ch);
        int d;
        wait_tick(ch, d);
    endtask

    task automatic measure_period(input int ch, output int p);
        int t1, t2;
        wait_tick(ch, t1);
        wait_tick(ch, t2);
        p = t2 - t1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   t, a, t1, t2, base, bad, p;
        vec_t vt[4];

        vt[0] = '{0, 2};
        vt[1] = '{1, 2};
        vt[2] = '{4, 8};
        vt[3] = '{3, 6};

        // ---- reset state ----------------------------------------------------
        step();
        step();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_ack", int'(div_ack), 0);

        // ---- default half 3, only ch0 enabled: period 6 ----------------------
        rst_n = 1'b1;
        ch_en = 5'b00001;
        base  = cyc;
        exp_tick_q.push_back(base + 3);
        exp_tick_q.push_back(base + 9);
        exp_tick_q.push_back(base + 15);
        mon = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("a_clk0", int'(clk_out[0]), (k >= 3 && ((k - 3) / 3) % 2 == 0) ? 1 : 0);
            check("a_others", int'(clk_out[NCH-1:1]) | int'(tick[NCH-1:1]), 0);
        end
        mon_done();

        // ---- write 5 in high phase: applied at the falling wrap --------------
        sync_tick(0);
        t = cyc;
        exp_ack_q.push_back(t + 3);
        exp_tick_q.push_back(t + 8);
        exp_tick_q.push_back(t + 18);
        mon = 1'b1;
        write(0, 5);
        check("b_still_high", int'(clk_out[0]), 1);
        run_to(t + 19);
        mon_done();

        // ---- two writes before boundary: last wins, single ack ---------------
        sync_tick(0);
        t = cyc;
        exp_ack_q.push_back(t + 5);
        exp_tick_q.push_back(t + 7);
        exp_tick_q.push_back(t + 11);
        exp_tick_q.push_back(t + 15);
        mon = 1'b1;
        write(0, 7);
        write(0, 2);
        run_to(t + 16);
        mon_done();

        // ---- table: divisor -> period ----------------------------------------
        for (int i = 0; i < 4; i++) begin
            sync_tick(0);
            write(0, vt[i].val);
            wait_ack(0, a);
            check("tbl_ack_clk_low", int'(clk_out[0]), 0);
            wait_tick(0, t1);
            check("tbl_first_high", t1 - a, vt[i].period / 2);
            wait_tick(0, t2);
            check("tbl_period", t2 - t1, vt[i].period);
        end

        // ---- out-of-range selects: no ack, no change --------------------------
        sync_tick(0);
        t   = cyc;
        bad = 0;
        write(5, 9);
        if (|div_ack) bad = 1;
        write(7, 9);
        if (|div_ack) bad = 1;
        while (cyc < t + 19) begin
            step();
            if (|div_ack) bad = 1;
        end
        check("oor_no_ack", bad, 0);
        measure_period(0, p);
        check("oor_period", p, 6);

        // ---- write landing on the apply cycle --------------------------------
        sync_tick(0);
        t = cyc;
        exp_ack_q.push_back(t + 3);
        exp_ack_q.push_back(t + 7);
        exp_tick_q.push_back(t + 5);
        exp_tick_q.push_back(t + 10);
        exp_tick_q.push_back(t + 16);
        mon = 1'b1;
        write(0, 2);
        step();
        write(0, 3);
        run_to(t + 17);
        mon_done();

        // ---- disable while high, write 4 while off, re-enable -----------------
        sync_tick(0);
        t = cyc;
        exp_ack_q.push_back(t + 3);
        exp_tick_q.push_back(t + 7);
        exp_tick_q.push_back(t + 15);
        mon   = 1'b1;
        ch_en = 5'b00000;
        step();
        check("f_clk_low1", int'(clk_out[0]), 0);
        write(0, 4);
        check("f_clk_low2", int'(clk_out[0]), 0);
        step();
        check("f_clk_low3", int'(clk_out[0]), 0);
        ch_en = 5'b00001;
        run_to(t + 16);
        mon_done();

        // ---- channel independence --------------------------------------------
        ch_en = 5'b00011;
        write(1, 2);
        wait_ack(1, a);
        check("g_no_ack_ch0", int'(div_ack[0]), 0);
        measure_period(1, p);
        check("g_ch1_period", p, 4);
        measure_period(0, p);
        check("g_ch0_period", p, 8);
        check("g_idle_chs", int'(clk_out[NCH-1:2]), 0);
        ch_en = 5'b00001;

        // ---- reset mid-operation discards the pending write -------------------
        sync_tick(0);
        write(0, 6);
        #3;
        rst_n = 1'b0;
        #1;
        check("h_async_clk", int'(clk_out), 0);
        check("h_async_tick", int'(tick), 0);
        check("h_async_ack", int'(div_ack), 0);
        step();
        rst_n = 1'b1;
        base  = cyc;
        exp_tick_q.push_back(base + 3);
        exp_tick_q.push_back(base + 9);
        mon = 1'b1;
        run_to(base + 14);
        mon_done();

`ifdef CLK_DIV_BANK_PAUSE_EN
        // ---- pause 10 cycles mid-period, write captured but held -------------
        sync_tick(0);
        t = cyc;
        step();
        exp_ack_q.push_back(t + 13);
        exp_tick_q.push_back(t + 15);
        exp_tick_q.push_back(t + 19);
        mon   = 1'b1;
        pause = 1'b1;
        write(0, 2);
        check("p_hold", int'(clk_out[0]), 1);
        for (int i = 0; i < 9; i++) begin
            step();
            check("p_hold", int'(clk_out[0]), 1);
        end
        pause = 1'b0;
        run_to(t + 20);
        mon_done();

        // ---- asynchronous reset while paused ---------------------------------
        sync_tick(0);
        pause = 1'b1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("p_rst_clk", int'(clk_out), 0);
        check("p_rst_tick", int'(tick), 0);
        check("p_rst_ack", int'(div_ack), 0);
        step();
        rst_n = 1'b1;
        pause = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
